// File: rtl/regfile32.sv
// regfile32: 32 x WIDTH register file, two combinational read ports, one clocked write port, r0 reads zero.
// Optional same-cycle write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile32 #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [DEPTH_LOG2-1:0] WriteRegister,
    input  logic [WIDTH-1:0]      WriteData,
    input  logic [DEPTH_LOG2-1:0] ReadRegister1,
    input  logic [DEPTH_LOG2-1:0] ReadRegister2,
    output logic [WIDTH-1:0]      ReadData1,
    output logic [WIDTH-1:0]      ReadData2
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Register 0 has no storage; the array starts at index 1.
    logic [WIDTH-1:0] r_mem [1:DEPTH-1];
    logic             w_wr_en;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    // Qualified write strobe: reset wins and writes to register 0 are dropped.
    always_comb begin
        w_wr_en = 1'b0;
        if (!reset && RegWrite && (WriteRegister != {DEPTH_LOG2{1'b0}})) begin
            w_wr_en = 1'b1;
        end else begin
            w_wr_en = 1'b0;
        end
    end

    // Storage update: synchronous clear of every register, else a single write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_wr_en) begin
            r_mem[WriteRegister] <= WriteData;
        end
    end

    // Read port 1: zero during reset or for r0, optional forwarding, else stored value.
    always_comb begin
        w_rd1 = {WIDTH{1'b0}};
        if (reset) begin
            w_rd1 = {WIDTH{1'b0}};
        end else if (ReadRegister1 == {DEPTH_LOG2{1'b0}}) begin
            w_rd1 = {WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (w_wr_en && (ReadRegister1 == WriteRegister)) begin
            w_rd1 = WriteData;
`endif
        end else begin
            w_rd1 = r_mem[ReadRegister1];
        end
    end

    // Read port 2: same rules as port 1, fully independent.
    always_comb begin
        w_rd2 = {WIDTH{1'b0}};
        if (reset) begin
            w_rd2 = {WIDTH{1'b0}};
        end else if (ReadRegister2 == {DEPTH_LOG2{1'b0}}) begin
            w_rd2 = {WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (w_wr_en && (ReadRegister2 == WriteRegister)) begin
            w_rd2 = WriteData;
`endif
        end else begin
            w_rd2 = r_mem[ReadRegister2];
        end
    end

    assign ReadData1 = w_rd1;
    assign ReadData2 = w_rd2;

endmodule
